mag_sqrt_engine: RTL and testbench

Parametrised vector-magnitude unit: accepts N_CH integer components, forms the sum of squares with one shared multiplier, and extracts the integer square root one result bit per cycle. It is the next-generation magnitude calculator for the Tiny Tapeout top-level wrappers. It adds valid/ready handshakes on both sides, a configurable channel count and input width, a signed-input mode, the remainder as an output, and optional round-to-nearest.

---
 rtl/mag_sqrt_engine.sv | 210 +++++++++++++++++++++
 tb/tb_mag_sqrt_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mag_sqrt_engine.sv
// mag_sqrt_engine: vector magnitude unit.
// Squares N_CH components one per cycle through a single multiplier, sums
// them into an accumulator, then extracts the integer square root one
// result bit per cycle (restoring digit-by-digit method).
// Optional feature macro: MAG_ROUND_EN (round-to-nearest on out_data).
// Without it out_data is floor(sqrt(S)) and no rounding logic is built.
// out_rem is always the floor remainder S - floor(sqrt(S))^2.
module mag_sqrt_engine #(
    parameter  int IN_W      = 8,
    parameter  int N_CH      = 2,
    parameter  int SIGNED_IN = 0,
    localparam int SS_W      = 2*IN_W + $clog2(N_CH),
    localparam int OUT_W     = (SS_W + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*IN_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [OUT_W:0]         out_rem,
    output logic                   busy
);

    localparam int CH_W  = (N_CH > 1)  ? $clog2(N_CH)  : 1;
    localparam int BC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PAD_W = 2*OUT_W;
    localparam int SQ_W  = 2*IN_W;
    localparam int TR_W  = OUT_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ROOT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // State and datapath registers with their next-state values
    state_t                 state_q,     state_d;
    logic [N_CH*IN_W-1:0]   in_lat_q,    in_lat_d;
    logic [SS_W-1:0]        acc_q,       acc_d;
    logic [CH_W-1:0]        ch_cnt_q,    ch_cnt_d;
    logic [OUT_W-1:0]       root_q,      root_d;
    logic [OUT_W:0]         rem_q,       rem_d;
    logic [BC_W-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [OUT_W-1:0]       out_data_q,  out_data_d;
    logic [OUT_W:0]         out_rem_q,   out_rem_d;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    // Datapath intermediates
    logic [IN_W-1:0]        comp_s;
    logic [IN_W-1:0]        mag_s;
    logic [SQ_W-1:0]        sq_s;
    logic [PAD_W-1:0]       acc_pad_s;
    logic [1:0]             pair_s;
    logic [TR_W-1:0]        rem_trial_s;
    logic [TR_W-1:0]        trial_s;
    logic [TR_W-1:0]        diff_s;
    logic [OUT_W-1:0]       root_step_s;
    logic [OUT_W:0]         rem_step_s;
    logic [OUT_W-1:0]       rounded_s;

    // Select the current channel and take its magnitude (absolute value in signed mode)
    always_comb begin
        comp_s = in_lat_q[int'(ch_cnt_q)*IN_W +: IN_W];
        mag_s  = comp_s;
        if ((SIGNED_IN != 0) && comp_s[IN_W-1]) begin
            // Most-negative value wraps to 2^(IN_W-1), which is its correct unsigned magnitude
            mag_s = ~comp_s + {{(IN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = comp_s;
        end
        sq_s = SQ_W'(mag_s) * SQ_W'(mag_s);
    end

    // One restoring square-root step: bring down the next radicand bit pair and try root*4+1
    always_comb begin
        acc_pad_s   = PAD_W'(acc_q);
        pair_s      = acc_pad_s[2*int'(bit_cnt_q) +: 2];
        rem_trial_s = {rem_q, pair_s};
        trial_s     = {1'b0, root_q, 2'b01};
        diff_s      = rem_trial_s - trial_s;
        if (rem_trial_s >= trial_s) begin
            root_step_s = {root_q[OUT_W-2:0], 1'b1};
            rem_step_s  = diff_s[OUT_W:0];
        end else begin
            root_step_s = {root_q[OUT_W-2:0], 1'b0};
            rem_step_s  = rem_trial_s[OUT_W:0];
        end
    end

`ifdef MAG_ROUND_EN
    // Round to nearest: sqrt(S) >= r + 0.5 exactly when the floor remainder exceeds r
    always_comb begin
        if (rem_step_s > {1'b0, root_step_s}) begin
            if (&root_step_s) begin
                rounded_s = root_step_s;
            end else begin
                rounded_s = root_step_s + {{(OUT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rounded_s = root_step_s;
        end
    end
`else
    // Truncating build: the result is the floor root
    always_comb begin
        rounded_s = root_step_s;
    end
`endif

    // Next-state and datapath-update logic for the IDLE/ACC/ROOT/DONE sequence
    always_comb begin
        state_d    = state_q;
        in_lat_d   = in_lat_q;
        acc_d      = acc_q;
        ch_cnt_d   = ch_cnt_q;
        root_d     = root_q;
        rem_d      = rem_q;
        bit_cnt_d  = bit_cnt_q;
        out_data_d = out_data_q;
        out_rem_d  = out_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_lat_d = in_data;
                    acc_d    = {SS_W{1'b0}};
                    ch_cnt_d = {CH_W{1'b0}};
                    state_d  = ST_ACC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + SS_W'(sq_s);
                if (ch_cnt_q == CH_W'(N_CH - 1)) begin
                    root_d    = {OUT_W{1'b0}};
                    rem_d     = {(OUT_W+1){1'b0}};
                    bit_cnt_d = BC_W'(OUT_W - 1);
                    state_d   = ST_ROOT;
                end else begin
                    ch_cnt_d  = ch_cnt_q + {{(CH_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ROOT: begin
                root_d = root_step_s;
                rem_d  = rem_step_s;
                if (bit_cnt_q == {BC_W{1'b0}}) begin
                    out_data_d = rounded_s;
                    out_rem_d  = rem_step_s;
                    state_d    = ST_DONE;
                end else begin
                    bit_cnt_d  = bit_cnt_q - {{(BC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_lat_q    <= {(N_CH*IN_W){1'b0}};
            acc_q       <= {SS_W{1'b0}};
            ch_cnt_q    <= {CH_W{1'b0}};
            root_q      <= {OUT_W{1'b0}};
            rem_q       <= {(OUT_W+1){1'b0}};
            bit_cnt_q   <= {BC_W{1'b0}};
            out_data_q  <= {OUT_W{1'b0}};
            out_rem_q   <= {(OUT_W+1){1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_lat_q    <= in_lat_d;
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_rem_q   <= out_rem_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rem   = out_rem_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mag_sqrt_engine.sv
// Directed testbench for mag_sqrt_engine: default, 3-channel and signed builds.
module tb_mag_sqrt_engine;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_in_data;
    logic [8:0]  a_out_data;
    logic [9:0]  a_out_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [23:0] b_in_data;
    logic [8:0]  b_out_data;
    logic [9:0]  b_out_rem;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [15:0] c_in_data;
    logic [8:0]  c_out_data;
    logic [9:0]  c_out_rem;

    int checks;
    int errors;
    int sel;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [8:0]  s_out_data;
    logic [9:0]  s_out_rem;

    mag_sqrt_engine #(.IN_W(8), .N_CH(2), .SIGNED_IN(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_rem(a_out_rem), .busy(a_busy));

    mag_sqrt_engine #(.IN_W(8), .N_CH(3), .SIGNED_IN(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_rem(b_out_rem), .busy(b_busy));

    mag_sqrt_engine #(.IN_W(8), .N_CH(2), .SIGNED_IN(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_rem(c_out_rem), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the outputs of the instance under test to common observation signals
    always_comb begin
        case (sel)
            1: begin
                s_in_ready = b_in_ready; s_out_valid = b_out_valid; s_busy = b_busy;
                s_out_data = b_out_data; s_out_rem = b_out_rem;
            end
            2: begin
                s_in_ready = c_in_ready; s_out_valid = c_out_valid; s_busy = c_busy;
                s_out_data = c_out_data; s_out_rem = c_out_rem;
            end
            default: begin
                s_in_ready = a_in_ready; s_out_valid = a_out_valid; s_busy = a_busy;
                s_out_data = a_out_data; s_out_rem = a_out_rem;
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one vector into the selected instance; return once accepted (at the negedge after acceptance)
    task automatic send_vec(input int which, input logic [23:0] data, input string tag);
        int wait_n;
        sel = which;
        @(negedge clk);
        wait_n = 0;
        while (!s_in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check_val({tag, " in_ready"}, 32'(s_in_ready), 32'd1);
        case (which)
            1:       begin b_in_data = data;        b_in_valid = 1'b1; end
            2:       begin c_in_data = data[15:0];  c_in_valid = 1'b1; end
            default: begin a_in_data = data[15:0];  a_in_valid = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        // Scramble the inputs after acceptance; the latched vector must not follow
        a_in_data = 16'hFFFF; b_in_data = 24'hFFFFFF; c_in_data = 16'h7F7F;
    endtask

    // Wait for out_valid, counting edges since acceptance, and check the result
    task automatic wait_result(input logic [8:0] exp_d, input logic [9:0] exp_r,
                               input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!s_out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " out_data"}, 32'(s_out_data), 32'(exp_d));
        check_val({tag, " out_rem"}, 32'(s_out_rem), 32'(exp_r));
    endtask

    task automatic run_vec(input int which, input logic [23:0] data, input logic [8:0] exp_d,
                           input logic [9:0] exp_r, input int exp_lat, input string tag);
        send_vec(which, data, tag);
        wait_result(exp_d, exp_r, exp_lat, tag);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, " valid one cycle"}, 32'(s_out_valid), 32'd0);
        check_val({tag, " ready after hs"}, 32'(s_in_ready), 32'd1);
    endtask

    initial begin
        int hits;
        checks = 0;
        errors = 0;
        sel = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = 16'd0; b_in_data = 24'd0; c_in_data = 16'd0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;

        // Reset state (in_valid during reset must be ignored)
        repeat (2) @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 16'h0403;
        @(negedge clk);
        check_val("rst in_ready", 32'(a_in_ready), 32'd0);
        check_val("rst out_valid", 32'(a_out_valid), 32'd0);
        check_val("rst out_data", 32'(a_out_data), 32'd0);
        check_val("rst out_rem", 32'(a_out_rem), 32'd0);
        check_val("rst busy", 32'(a_busy), 32'd0);
        a_in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("post-rst in_ready", 32'(a_in_ready), 32'd1);
        check_val("post-rst busy", 32'(a_busy), 32'd0);

        // Default build: unsigned, two channels
        run_vec(0, {8'd0, 8'd4,   8'd3},   9'd5,   10'd0,   11, "a 3,4");
`ifdef MAG_ROUND_EN
        run_vec(0, {8'd0, 8'd255, 8'd255}, 9'd361, 10'd450, 11, "a 255,255");
        run_vec(0, {8'd0, 8'd4,   8'd4},   9'd6,   10'd7,   11, "a 4,4");
`else
        run_vec(0, {8'd0, 8'd255, 8'd255}, 9'd360, 10'd450, 11, "a 255,255");
        run_vec(0, {8'd0, 8'd4,   8'd4},   9'd5,   10'd7,   11, "a 4,4");
`endif
        run_vec(0, {8'd0, 8'd0,   8'd0},   9'd0,   10'd0,   11, "a 0,0");
        run_vec(0, {8'd0, 8'd2,   8'd1},   9'd2,   10'd1,   11, "a 1,2");

        // Three-channel build
        run_vec(1, {8'd2, 8'd2, 8'd1}, 9'd3, 10'd0, 12, "b 1,2,2");
        run_vec(1, {8'd7, 8'd0, 8'd0}, 9'd7, 10'd0, 12, "b 0,0,7");

        // Signed build
        run_vec(2, {8'd0, 8'hFC, 8'hFD}, 9'd5,   10'd0,   11, "c -3,-4");
        run_vec(2, {8'd0, 8'h00, 8'h80}, 9'd128, 10'd0,   11, "c -128,0");
        run_vec(2, {8'd0, 8'h80, 8'h7F}, 9'd180, 10'd113, 11, "c 127,-128");

        // Backpressure: hold out_ready low in DONE for 20 cycles with a competing in_valid
        a_out_ready = 1'b0;
        send_vec(0, {8'd0, 8'd8, 8'd6}, "bp");
        wait_result(9'd10, 10'd0, 11, "bp");
        a_in_valid = 1'b1;
        a_in_data  = 16'h0101;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("bp hold valid", 32'(a_out_valid), 32'd1);
            check_val("bp hold data", 32'(a_out_data), 32'd10);
            check_val("bp hold rem", 32'(a_out_rem), 32'd0);
            check_val("bp in_ready", 32'(a_in_ready), 32'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp release valid", 32'(a_out_valid), 32'd0);
        check_val("bp release ready", 32'(a_in_ready), 32'd1);
        check_val("bp release busy", 32'(a_busy), 32'd0);

        // Reset during the root phase (around bit 4)
        send_vec(0, {8'd0, 8'd4, 8'd3}, "midrst");
        repeat (6) @(negedge clk);
        check_val("midrst busy before", 32'(a_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst out_valid", 32'(a_out_valid), 32'd0);
        check_val("midrst busy", 32'(a_busy), 32'd0);
        check_val("midrst in_ready low", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("midrst in_ready", 32'(a_in_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_out_valid) hits++;
        end
        check_val("midrst no valid", 32'(hits), 32'd0);
        run_vec(0, {8'd0, 8'd8, 8'd6}, 9'd10, 10'd0, 11, "midrst 6,8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
